// File: rtl/vga_pkg.sv
`default_nettype none
//==============================================================================
// Package  : vga_pkg
// Brief    : Shared 640x480@60 raster constants, frame buffer geometry and
//            pixel/state types for the VGA frame reader.
// Revision : 1.0 - initial release
//==============================================================================
package vga_pkg;

  // Horizontal raster, in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  // Vertical raster, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Stored frame, shown pixel-doubled in both directions
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  localparam int ADDR_W   = 17;
  localparam int CNT_W    = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_SHOW = 1'b1
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_frame_reader_if.sv
`default_nettype none
//==============================================================================
// Interface : vga_frame_reader_if
// Brief     : Frame buffer BRAM read port (address out, RGB444 data back).
// Revision  : 1.0 - initial release
//==============================================================================
interface vga_frame_reader_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  rgb444_t           rd_data;

  modport master (output rd_addr, input  rd_data);
  modport slave  (input  rd_addr, output rd_data);

endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
//==============================================================================
// Module   : vga_timing
// Brief    : Free-running raster counters with raw sync, active-region and
//            frame-origin flags, all decoded from the current count.
// Revision : 1.0 - initial release
//==============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  wire              i_clk,
  input  wire              i_rst,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic             o_frame_origin
);

  localparam int H_PERIOD = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int V_PERIOD = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam int HS_FIRST = H_ACT + H_FRONT;
  localparam int HS_LAST  = HS_FIRST + H_PULSE - 1;
  localparam int VS_FIRST = V_ACT + V_FRONT;
  localparam int VS_LAST  = VS_FIRST + V_PULSE - 1;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_line_end;
  logic             w_frame_end;

  assign w_line_end  = (r_h_cnt == CNT_W'(H_PERIOD - 1));
  assign w_frame_end = w_line_end && (r_v_cnt == CNT_W'(V_PERIOD - 1));

  // Horizontal count wraps every line; vertical count steps on that wrap
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  assign o_h_cnt        = r_h_cnt;
  assign o_v_cnt        = r_v_cnt;
  assign o_hsync        = ~((r_h_cnt >= CNT_W'(HS_FIRST)) && (r_h_cnt <= CNT_W'(HS_LAST)));
  assign o_vsync        = ~((r_v_cnt >= CNT_W'(VS_FIRST)) && (r_v_cnt <= CNT_W'(VS_LAST)));
  assign o_active       = (r_h_cnt < CNT_W'(H_ACT)) && (r_v_cnt < CNT_W'(V_ACT));
  assign o_frame_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
//==============================================================================
// Module   : vga_frame_reader
// Brief    : VGA raster generator that fetches a half-resolution RGB444 frame
//            from BRAM, shows each stored pixel as a 2x2 block and keeps
//            sync/de/colour aligned across the BRAM read latency.
// Revision : 1.0 - initial release
//==============================================================================
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RD_LAT  = 1,          // BRAM read latency, 1 or 2
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  wire                i_clk,
  input  wire                i_rst,
  input  wire                i_en,
  vga_frame_reader_if.master fb,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [3:0]         o_red,
  output logic [3:0]         o_green,
  output logic [3:0]         o_blue,
  output logic               o_frame_start
);

  localparam int H_PERIOD  = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int V_PERIOD  = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam int FB_STRIDE = H_ACT / 2;

  logic [CNT_W-1:0]  w_h_cnt;
  logic [CNT_W-1:0]  w_v_cnt;
  logic              w_hsync_raw;
  logic              w_vsync_raw;
  logic              w_active;
  logic              w_frame_origin;
  logic              w_line_end;
  logic              w_frame_end;
  logic              w_show;

  logic [ADDR_W-1:0] r_line_base;
  logic [CNT_W-1:0]  r_col;
  disp_state_t       r_state;
  logic              r_de_s1;
  logic              r_fs_s1;
  logic              r_hs_s1;
  logic              r_vs_s1;
  logic [RD_LAT-1:0] r_hs_dly;
  logic [RD_LAT-1:0] r_vs_dly;
  logic [RD_LAT-1:0] r_de_dly;
  logic [RD_LAT-1:0] r_fs_dly;

  vga_timing #(
    .H_ACT   (H_ACT),
    .H_FRONT (H_FRONT),
    .H_PULSE (H_PULSE),
    .H_BACK  (H_BACK),
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_PULSE (V_PULSE),
    .V_BACK  (V_BACK)
  ) u_timing (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_h_cnt        (w_h_cnt),
    .o_v_cnt        (w_v_cnt),
    .o_hsync        (w_hsync_raw),
    .o_vsync        (w_vsync_raw),
    .o_active       (w_active),
    .o_frame_origin (w_frame_origin)
  );

  assign w_line_end  = (w_h_cnt == CNT_W'(H_PERIOD - 1));
  assign w_frame_end = w_line_end && (w_v_cnt == CNT_W'(V_PERIOD - 1));

  // A pixel is shown only while enabled, and showing may only begin at (0,0)
  assign w_show = i_en && ((r_state == ST_SHOW) || w_frame_origin);

  // Incremental address: col steps on odd h, line_base steps after odd lines
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col       <= '0;
      r_line_base <= '0;
      fb.rd_addr  <= '0;
    end else begin
      fb.rd_addr <= w_active ? (r_line_base + ADDR_W'(r_col)) : '0;

      if (w_line_end) begin
        r_col <= '0;
      end else if (w_active && w_h_cnt[0]) begin
        r_col <= r_col + CNT_W'(1);
      end

      if (w_frame_end) begin
        r_line_base <= '0;
      end else if (w_line_end && w_v_cnt[0] && (w_v_cnt < CNT_W'(V_ACT))) begin
        r_line_base <= r_line_base + ADDR_W'(FB_STRIDE);
      end
    end
  end

  // Enable FSM; its registered outputs are the gated de and frame-start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_WAIT;
      r_de_s1 <= 1'b0;
      r_fs_s1 <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: if (i_en && w_frame_origin) r_state <= ST_SHOW;
        ST_SHOW: if (!i_en)                  r_state <= ST_WAIT;
        default:                             r_state <= ST_WAIT;
      endcase
      r_de_s1 <= w_show && w_active;
      r_fs_s1 <= w_show && w_frame_origin;
    end
  end

  // Delay line carrying sync/de/frame-start across the BRAM read latency
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_s1  <= 1'b1;
      r_vs_s1  <= 1'b1;
      r_hs_dly <= '1;
      r_vs_dly <= '1;
      r_de_dly <= '0;
      r_fs_dly <= '0;
    end else begin
      r_hs_s1  <= w_hsync_raw;
      r_vs_s1  <= w_vsync_raw;
      r_hs_dly <= RD_LAT'({r_hs_dly, r_hs_s1});
      r_vs_dly <= RD_LAT'({r_vs_dly, r_vs_s1});
      r_de_dly <= RD_LAT'({r_de_dly, r_de_s1});
      r_fs_dly <= RD_LAT'({r_fs_dly, r_fs_s1});
    end
  end

  // Output stage: colour passes only where the aligned de marks a shown pixel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
    end else begin
      o_hsync       <= r_hs_dly[RD_LAT-1];
      o_vsync       <= r_vs_dly[RD_LAT-1];
      o_de          <= r_de_dly[RD_LAT-1];
      o_frame_start <= r_fs_dly[RD_LAT-1];
      if (r_de_dly[RD_LAT-1]) begin
        o_red   <= fb.rd_data.r;
        o_green <= fb.rd_data.g;
        o_blue  <= fb.rd_data.b;
      end else begin
        o_red   <= '0;
        o_green <= '0;
        o_blue  <= '0;
      end
    end
  end

endmodule
`default_nettype wire
